multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational opcode decoder of the 16-bit CPU.
- FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and handshakes with instruction and data memory (req/ack).
- Emits per-state datapath strobes; takes the zero flag for branch resolution.
- Supports HALT/resume, illegal-opcode fault and a retired-instruction counter.
- Sits between the instruction register, datapath and memory port.

Parameters:
- OPCODE_W, 4, opcode field width; opcode/ALU encodings come from the shared opcode definition header.
- ALU_OP_W, 4, width of alu_op.
- CNT_W, 16, retired-instruction counter width.
- MEM_TIMEOUT, 15, max wait cycles for any ack (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode field of the instruction register, valid from DECODE.
- zero  in  1  ALU zero flag, valid in EXECUTE.
- imem_ack  in  1  instruction memory ack.
- dmem_ack  in  1  data memory ack.
- resume  in  1  1-cycle pulse leaving HALT.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  1  0=PC+2, 1=branch target.
- alu_src  out  1  0=register, 1=immediate.
- alu_op  out  ALU_OP_W  ALU operation.
- mem_read  out  1  data read request.
- mem_write  out  1  data write request.
- mem_to_reg  out  1  writeback select memory.
- reg_write  out  1  register file write enable.
- halted  out  1  in HALT.
- fault  out  1  sticky fault.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset: state=RST, op_q=0, instr_count=0.
  - All outputs 0; alu_op=ALU_ADD.
  - RST always moves to FETCH on the next cycle.
- Outputs are Moore-decoded from the state register and op_q.
  - Strobes not listed for a state are 0; alu_op defaults to ALU_ADD.
- FETCH:
  - imem_req=1, held until imem_ack.
  - In the ack cycle, ir_write=1 and pc_write=1 (pc_src=0); next state DECODE.
- DECODE (1 cycle): op_q<=opcode.
  - Illegal opcode (no match in the header) -> FAULT.
  - HALT -> HALT.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle):
  - ADD/SUB/AND/OR/XOR/SLT: alu_op as named, alu_src=0 -> WB.
  - ADDI/ANDI/ORI/XORI: alu_src=1, ALU op ADD/AND/OR/XOR -> WB.
  - LOAD/STORE: alu_src=1, ALU_ADD -> MEM.
  - BEQ/BNE: alu_op=ALU_SUB, alu_src=1.
    - Taken when zero==1 for BEQ, or zero==0 for BNE; taken asserts pc_write=1, pc_src=1 in this cycle.
    - Next state FETCH; the instruction retires.
- MEM:
  - LOAD holds mem_read=1; STORE holds mem_write=1.
  - Held until dmem_ack; address operands (alu_src=1, ALU_ADD) stay held.
  - On ack: LOAD -> WB; STORE retires -> FETCH.
- WB (1 cycle): reg_write=1; mem_to_reg=1 for LOAD only; retires -> FETCH.
- HALT: halted=1, no strobes. resume=1 -> FETCH; otherwise stay.
- FAULT: fault=1, no strobes; sticky until rst_n.
- Retire: instr_count+1 in the retiring cycle.
  - Wraps modulo 2^CNT_W.
  - HALT and faulting instructions do not count.
- Acks asserted outside the waiting state are ignored.
- Ack in the same cycle as the request is legal; minimum FETCH is 1 cycle.
- rst_n low in any state returns to RST immediately, even mid-handshake.
  - Requests drop asynchronously; the counter clears.
- Cycle counts (zero wait): R/I-type 4, branch 3, STORE 4, LOAD 5.

Optional Feature:
- Macro MULTICYCLE_CONTROL_TIMEOUT_EN.
- Defined: a wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - Reaching MEM_TIMEOUT cycles without ack -> FAULT; the request drops.
  - An ack in the same cycle the counter hits MEM_TIMEOUT wins.
- Undefined: no counter; the FSM waits indefinitely for ack.

Test Plan:
- Reset, then ADD with imem_ack one cycle after req -> imem_req 2 cycles, DECODE, EXECUTE alu_op=ALU_ADD, WB reg_write=1; instr_count=1.
- LOAD with dmem_ack after 3 wait cycles -> mem_read high 4 cycles, then WB with mem_to_reg=1 and reg_write=1; STORE -> mem_write until ack, no reg_write.
- BEQ with zero=1 -> pc_write=1, pc_src=1 in EXECUTE; BNE with zero=1 -> no pc_write, next FETCH.
- HALT -> halted=1 for 10 cycles with no strobes, count unchanged; resume pulse -> FETCH next cycle.
- Illegal opcode -> fault=1, held through resume; rst_n low mid-MEM -> all outputs 0 asynchronously, count 0.
- TIMEOUT_EN with MEM_TIMEOUT=15 and no dmem_ack -> FAULT after 15 wait cycles; with CNT_W=4, 16 retirements -> instr_count wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// =============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle FSM controller for the 16-bit CPU. Sequences
//            FETCH/DECODE/EXECUTE/MEM/WRITEBACK, handshakes with instruction
//            and data memory, resolves branches from the zero flag, and
//            supports HALT/resume, a sticky illegal-opcode fault and a
//            retired-instruction counter.
// Options  : `define MULTICYCLE_CONTROL_TIMEOUT_EN to fault after MEM_TIMEOUT
//            wait cycles without an ack in FETCH or MEM.
// Revision : 1.0 - initial release
// =============================================================================
module multicycle_control #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                resume,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_count
);

  // Shared opcode definitions of the 16-bit CPU
  localparam logic [OPCODE_W-1:0] c_OP_ADD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] c_OP_SUB   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] c_OP_AND   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] c_OP_OR    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] c_OP_XOR   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] c_OP_SLT   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] c_OP_ADDI  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] c_OP_ANDI  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] c_OP_ORI   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] c_OP_XORI  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] c_OP_LOAD  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] c_OP_STORE = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] c_OP_BEQ   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] c_OP_BNE   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] c_OP_HALT  = OPCODE_W'(14);

  // Shared ALU operation encodings
  localparam logic [ALU_OP_W-1:0] c_ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] c_ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] c_ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] c_ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] c_ALU_XOR = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] c_ALU_SLT = ALU_OP_W'(5);

  // Controller states
  localparam logic [2:0] c_ST_RST    = 3'd0;
  localparam logic [2:0] c_ST_FETCH  = 3'd1;
  localparam logic [2:0] c_ST_DECODE = 3'd2;
  localparam logic [2:0] c_ST_EXEC   = 3'd3;
  localparam logic [2:0] c_ST_MEM    = 3'd4;
  localparam logic [2:0] c_ST_WB     = 3'd5;
  localparam logic [2:0] c_ST_HALT   = 3'd6;
  localparam logic [2:0] c_ST_FAULT  = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                w_op_legal;
  logic                w_taken;
  logic                w_retire;
  logic                w_timeout;

  // A zero timeout would fault every handshake before an ack could be seen
  if (MEM_TIMEOUT < 1) begin : g_timeout_range_check
    $error("multicycle_control: MEM_TIMEOUT must be at least 1");
  end

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic                w_waiting;

  // Count cycles spent in FETCH/MEM without ack; an ack on the limit cycle wins
  always_comb begin
    w_waiting = ((state_q == c_ST_FETCH) && !imem_ack) ||
                ((state_q == c_ST_MEM)   && !dmem_ack);
    w_timeout = w_waiting && (wait_q == c_WAIT_W'(MEM_TIMEOUT));
    wait_d    = (w_waiting && !w_timeout) ? wait_q + c_WAIT_W'(1) : '0;
  end

  // Wait counter register, cleared whenever a handshake is not pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Opcode legality check against the shared opcode table
  always_comb begin
    w_op_legal = 1'b0;
    case (opcode)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_SLT,
      c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_XORI,
      c_OP_LOAD, c_OP_STORE, c_OP_BEQ, c_OP_BNE, c_OP_HALT: w_op_legal = 1'b1;
      default:                                              w_op_legal = 1'b0;
    endcase
  end

  assign w_taken = ((op_q == c_OP_BEQ) && zero) || ((op_q == c_OP_BNE) && !zero);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_ST_RST;
    else        state_q <= state_d;
  end

  // Next-state logic; also flags the cycle in which an instruction retires
  always_comb begin
    state_d  = state_q;
    w_retire = 1'b0;
    case (state_q)
      c_ST_RST:    state_d = c_ST_FETCH;
      c_ST_FETCH: begin
        if (imem_ack)       state_d = c_ST_DECODE;
        else if (w_timeout) state_d = c_ST_FAULT;
      end
      c_ST_DECODE: begin
        if (!w_op_legal)              state_d = c_ST_FAULT;
        else if (opcode == c_OP_HALT) state_d = c_ST_HALT;
        else                          state_d = c_ST_EXEC;
      end
      c_ST_EXEC: begin
        if ((op_q == c_OP_LOAD) || (op_q == c_OP_STORE)) begin
          state_d = c_ST_MEM;
        end else if ((op_q == c_OP_BEQ) || (op_q == c_OP_BNE)) begin
          state_d  = c_ST_FETCH;
          w_retire = 1'b1;
        end else begin
          state_d = c_ST_WB;
        end
      end
      c_ST_MEM: begin
        if (dmem_ack) begin
          if (op_q == c_OP_LOAD) begin
            state_d = c_ST_WB;
          end else begin
            state_d  = c_ST_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_timeout) begin
          state_d = c_ST_FAULT;
        end
      end
      c_ST_WB: begin
        state_d  = c_ST_FETCH;
        w_retire = 1'b1;
      end
      c_ST_HALT:  if (resume) state_d = c_ST_FETCH;
      c_ST_FAULT: state_d = c_ST_FAULT;
      default:    state_d = c_ST_RST;
    endcase
  end

  // Datapath strobes decoded from the state and the latched opcode
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = c_ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      c_ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      c_ST_EXEC: begin
        case (op_q)
          c_OP_SUB:  alu_op = c_ALU_SUB;
          c_OP_AND:  alu_op = c_ALU_AND;
          c_OP_OR:   alu_op = c_ALU_OR;
          c_OP_XOR:  alu_op = c_ALU_XOR;
          c_OP_SLT:  alu_op = c_ALU_SLT;
          c_OP_ADDI: alu_src = 1'b1;
          c_OP_ANDI: begin alu_src = 1'b1; alu_op = c_ALU_AND; end
          c_OP_ORI:  begin alu_src = 1'b1; alu_op = c_ALU_OR;  end
          c_OP_XORI: begin alu_src = 1'b1; alu_op = c_ALU_XOR; end
          c_OP_LOAD, c_OP_STORE: alu_src = 1'b1;
          c_OP_BEQ, c_OP_BNE: begin
            alu_src = 1'b1;
            alu_op  = c_ALU_SUB;
            if (w_taken) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
          end
          default: alu_op = c_ALU_ADD;
        endcase
      end
      c_ST_MEM: begin
        // Address operands stay on the ALU for the whole handshake
        alu_src   = 1'b1;
        mem_read  = (op_q == c_OP_LOAD);
        mem_write = (op_q == c_OP_STORE);
      end
      c_ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == c_OP_LOAD);
      end
      c_ST_HALT:  halted = 1'b1;
      c_ST_FAULT: fault  = 1'b1;
      default:    imem_req = 1'b0;
    endcase
  end

  assign op_d    = (state_q == c_ST_DECODE) ? opcode : op_q;
  assign count_d = w_retire ? count_q + CNT_W'(1) : count_q;

  // Latched opcode and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      count_q <= '0;
    end else begin
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// =============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control. Each driven cycle
//            pushes its expected strobes and counter value to a scoreboard
//            that is popped and compared on the following falling edge.
// Revision : 1.0 - initial release
// =============================================================================
module tb_multicycle_control;

  localparam int c_TO = 15;

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_AND   = 4'd2;
  localparam logic [3:0] c_OP_OR    = 4'd3;
  localparam logic [3:0] c_OP_XOR   = 4'd4;
  localparam logic [3:0] c_OP_SLT   = 4'd5;
  localparam logic [3:0] c_OP_ADDI  = 4'd6;
  localparam logic [3:0] c_OP_ANDI  = 4'd7;
  localparam logic [3:0] c_OP_ORI   = 4'd8;
  localparam logic [3:0] c_OP_XORI  = 4'd9;
  localparam logic [3:0] c_OP_LOAD  = 4'd10;
  localparam logic [3:0] c_OP_STORE = 4'd11;
  localparam logic [3:0] c_OP_BEQ   = 4'd12;
  localparam logic [3:0] c_OP_BNE   = 4'd13;
  localparam logic [3:0] c_OP_HALT  = 4'd14;
  localparam logic [3:0] c_OP_ILL   = 4'd15;

  localparam logic [3:0] c_ALU_ADD = 4'd0;
  localparam logic [3:0] c_ALU_SUB = 4'd1;
  localparam logic [3:0] c_ALU_AND = 4'd2;
  localparam logic [3:0] c_ALU_OR  = 4'd3;
  localparam logic [3:0] c_ALU_XOR = 4'd4;
  localparam logic [3:0] c_ALU_SLT = 4'd5;

  localparam logic [14:0] c_IDLE = 15'd0;

  logic       clk, rst_n;
  logic [3:0] opcode;
  logic       zero, imem_ack, dmem_ack, resume;
  logic       imem_req, ir_write, pc_write, pc_src, alu_src;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, mem_to_reg, reg_write, halted, fault;
  logic [3:0] instr_count;
  logic [14:0] w_obs;

  multicycle_control #(
    .OPCODE_W   (4),
    .ALU_OP_W   (4),
    .CNT_W      (4),
    .MEM_TIMEOUT(c_TO)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .resume     (resume),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  assign w_obs = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                  mem_read, mem_write, mem_to_reg, reg_write, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [14:0] outs;
    logic [3:0]  cnt;
  } sb_item_t;

  sb_item_t   sb_q[$];
  sb_item_t   mon_item;
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_cnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [14:0] ev(input logic req, irw, pcw, pcs, asrc,
                                     input logic [3:0] aop,
                                     input logic mr, mw, m2r, rw, h, f);
    return {req, irw, pcw, pcs, asrc, aop, mr, mw, m2r, rw, h, f};
  endfunction

  // Scoreboard consumer: compare one expected cycle per falling edge
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_item = sb_q.pop_front();
      check_val(mon_item.tag, 32'(w_obs), 32'(mon_item.outs));
      check_val({mon_item.tag, "_cnt"}, 32'(instr_count), 32'(mon_item.cnt));
    end
  end

  task automatic step(input logic ia, da, z, rs, input logic [3:0] op,
                      input logic [14:0] e, input string tag);
    sb_item_t it;
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    zero     = z;
    resume   = rs;
    opcode   = op;
    it.tag   = tag;
    it.outs  = e;
    it.cnt   = exp_cnt;
    sb_q.push_back(it);
  endtask

  task automatic fetch_phase(input int fw);
    for (int i = 0; i < fw; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(1,0,0,0,0,c_ALU_ADD,0,0,0,0,0,0), "fetch_wait");
    step(1'b1, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(1,1,1,0,0,c_ALU_ADD,0,0,0,0,0,0), "fetch_ack");
  endtask

  // Expected EXECUTE strobes for a legal non-HALT opcode
  function automatic logic [14:0] exec_exp(input logic [3:0] op, input logic z);
    logic [3:0] aop;
    logic       asrc, tk;
    aop  = c_ALU_ADD;
    asrc = 1'b0;
    tk   = 1'b0;
    case (op)
      c_OP_SUB:  aop = c_ALU_SUB;
      c_OP_AND:  aop = c_ALU_AND;
      c_OP_OR:   aop = c_ALU_OR;
      c_OP_XOR:  aop = c_ALU_XOR;
      c_OP_SLT:  aop = c_ALU_SLT;
      c_OP_ADDI: asrc = 1'b1;
      c_OP_ANDI: begin asrc = 1'b1; aop = c_ALU_AND; end
      c_OP_ORI:  begin asrc = 1'b1; aop = c_ALU_OR;  end
      c_OP_XORI: begin asrc = 1'b1; aop = c_ALU_XOR; end
      c_OP_LOAD, c_OP_STORE: asrc = 1'b1;
      c_OP_BEQ:  begin asrc = 1'b1; aop = c_ALU_SUB; tk = z;  end
      c_OP_BNE:  begin asrc = 1'b1; aop = c_ALU_SUB; tk = !z; end
      default:   aop = c_ALU_ADD;
    endcase
    return ev(0,0,tk,tk,asrc,aop,0,0,0,0,0,0);
  endfunction

  // One complete instruction: fw fetch waits, mw data waits, zero flag z
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    logic        is_ld;
    logic [14:0] mem_e;
    is_ld = (op == c_OP_LOAD);
    mem_e = ev(0,0,0,0,1,c_ALU_ADD,is_ld,!is_ld,0,0,0,0);
    fetch_phase(fw);
    // acks outside a waiting state must be ignored
    step(1'b1, 1'b1, !z, 1'b0, op, c_IDLE, $sformatf("decode_op%0d", op));
    step(1'b0, 1'b1, z, 1'b0, ~op, exec_exp(op, z), $sformatf("exec_op%0d", op));
    if ((op == c_OP_BEQ) || (op == c_OP_BNE)) begin
      exp_cnt++;
    end else if (is_ld || (op == c_OP_STORE)) begin
      for (int i = 0; i < mw; i++)
        step(1'b0, 1'b0, 1'b0, 1'b0, ~op, mem_e, $sformatf("mem_wait_op%0d", op));
      step(1'b0, 1'b1, 1'b0, 1'b0, ~op, mem_e, $sformatf("mem_ack_op%0d", op));
      if (is_ld) begin
        step(1'b1, 1'b1, 1'b0, 1'b0, ~op, ev(0,0,0,0,0,c_ALU_ADD,0,0,1,1,0,0), "wb_load");
      end
      exp_cnt++;
    end else begin
      step(1'b1, 1'b1, 1'b0, 1'b0, ~op, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,1,0,0), $sformatf("wb_op%0d", op));
      exp_cnt++;
    end
  endtask

  // Drop rst_n away from a clock edge and verify outputs clear immediately
  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val({tag, "_outs"}, 32'(w_obs), 32'(0));
    check_val({tag, "_cnt"}, 32'(instr_count), 32'(0));
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    zero     = 1'b0;
    resume   = 1'b0;
    opcode   = 4'd0;
    #1;
    rst_n   = 1'b1;
    exp_cnt = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    opcode   = 4'd0;
    zero     = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    resume   = 1'b0;
    exp_cnt  = 4'd0;

    repeat (2) @(negedge clk);
    #1;
    check_val("reset_outs", 32'(w_obs), 32'(0));
    check_val("reset_cnt", 32'(instr_count), 32'(0));
    #2;
    rst_n = 1'b1;

    // Arithmetic, immediate, memory and branch instructions
    run_instr(c_OP_ADD,   1, 0, 1'b0);
    run_instr(c_OP_SUB,   0, 0, 1'b0);
    run_instr(c_OP_AND,   0, 0, 1'b1);
    run_instr(c_OP_SLT,   2, 0, 1'b0);
    run_instr(c_OP_ADDI,  0, 0, 1'b0);
    run_instr(c_OP_ORI,   1, 0, 1'b0);
    run_instr(c_OP_LOAD,  0, 3, 1'b0);
    run_instr(c_OP_STORE, 0, 2, 1'b0);
    run_instr(c_OP_STORE, 0, 0, 1'b0);
    run_instr(c_OP_LOAD,  0, 0, 1'b1);
    run_instr(c_OP_BEQ,   0, 0, 1'b1);
    run_instr(c_OP_BNE,   0, 0, 1'b1);
    run_instr(c_OP_BEQ,   0, 0, 1'b0);
    run_instr(c_OP_BNE,   1, 0, 1'b0);

    // HALT: no strobes, count frozen, resume returns to FETCH
    fetch_phase(0);
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_HALT, c_IDLE, "halt_decode");
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,1,0), "halt_hold");
    step(1'b0, 1'b0, 1'b0, 1'b1, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,1,0), "halt_resume");
    run_instr(c_OP_XORI, 0, 0, 1'b0);

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    // Acks on the last allowed wait cycle still complete the handshake
    run_instr(c_OP_ADD,  c_TO, 0, 1'b0);
    run_instr(c_OP_LOAD, 0, c_TO, 1'b0);
    // No data ack at all: FAULT after the wait budget, request dropped
    fetch_phase(0);
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_LOAD, c_IDLE, "to_decode");
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, exec_exp(c_OP_LOAD, 1'b0), "to_exec");
    for (int i = 0; i <= c_TO; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(0,0,0,0,1,c_ALU_ADD,1,0,0,0,0,0), "to_mem_wait");
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,0,1), "to_fault");
    step(1'b0, 1'b1, 1'b0, 1'b1, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,0,1), "to_fault_hold");
    async_reset_check("to_reset");
`else
    // Without the timeout the controller waits as long as needed
    run_instr(c_OP_LOAD, 0, 20, 1'b0);
    run_instr(c_OP_ADD, 20, 0, 1'b0);
`endif

    // Illegal opcode: sticky fault that resume cannot clear
    fetch_phase(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, c_IDLE, "illegal_decode");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,0,1), "fault_hold");
    step(1'b0, 1'b0, 1'b0, 1'b1, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,0,1), "fault_resume");
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(0,0,0,0,0,c_ALU_ADD,0,0,0,0,0,1), "fault_after_resume");
    async_reset_check("fault_reset");

    // Reset in the middle of a data read
    run_instr(c_OP_ADD, 0, 0, 1'b0);
    fetch_phase(0);
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_LOAD, c_IDLE, "midmem_decode");
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, exec_exp(c_OP_LOAD, 1'b0), "midmem_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(0,0,0,0,1,c_ALU_ADD,1,0,0,0,0,0), "midmem_wait");
    step(1'b0, 1'b0, 1'b0, 1'b0, c_OP_ILL, ev(0,0,0,0,1,c_ALU_ADD,1,0,0,0,0,0), "midmem_wait");
    async_reset_check("midmem_reset");

    // Sixteen retirements from reset wrap the 4-bit counter to zero
    for (int i = 0; i < 16; i++)
      run_instr(4'(i % 14), i % 3, i % 4, 1'(i % 2));
    @(posedge clk);
    #2;
    check_val("count_wrap", 32'(instr_count), 32'(0));

    repeat (2) @(negedge clk);
    #1;
    check_val("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
